// File: rtl/tqvp_vga_write_scheduler.sv
// tqvp_vga_write_scheduler: queues CPU register writes and releases them only inside a raster-safe window.
module tqvp_vga_write_scheduler #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [1:0]               wr_size,
  output logic                     wr_ready,
  input  logic [1:0]               sync_mode,
  input  logic                     blank,
  input  logic                     vblank,
  input  logic                     fence_req,
  output logic                     fence_done,
  output logic                     commit_valid,
  output logic [ADDR_W-1:0]        commit_addr,
  output logic [DATA_W-1:0]        commit_data,
  output logic [1:0]               commit_size,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [1:0]        s;
  } ent_t;
  ent_t              mem_q [DEPTH];
  ent_t              commit_q;
  state_e            state_q, state_d;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              win, push, pop, fire;
  logic              pend_q, pend_d, commit_valid_q, fence_done_q, overflow_q;
  assign level        = level_q;
  assign commit_valid = commit_valid_q;
  assign commit_addr  = commit_q.a;
  assign commit_data  = commit_q.d;
  assign commit_size  = commit_q.s;
  assign fence_done   = fence_done_q;
  assign overflow     = overflow_q;
  // state is non-IDLE exactly when entries are queued, so a pop needs only an open window
  always_comb begin
    win      = (sync_mode == 2'b00) | ((sync_mode == 2'b01) & blank) | ((sync_mode == 2'b10) & vblank);
    wr_ready = level_q != LW'(DEPTH);
    push     = wr_valid & wr_ready;
    pop      = (state_q != IDLE) & win;
    level_d  = level_q + LW'(push) - LW'(pop);
    state_d  = (level_d == '0) ? IDLE : (win ? DRAIN : HOLD);
    fire     = (pend_q | fence_req) & (level_q == '0) & ~push;
    pend_d   = ~fire & (pend_q | fence_req);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= '{a: wr_addr, d: wr_data, s: wr_size};
  always_ff @(posedge clk)
    if (rst) begin
      state_q        <= IDLE;
      level_q        <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
      fence_done_q   <= 1'b0;
      pend_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      wptr_q         <= wptr_q + AW'(push);
      rptr_q         <= rptr_q + AW'(pop);
      commit_valid_q <= pop;
      if (pop) commit_q <= mem_q[rptr_q];
      fence_done_q   <= fire;
      pend_q         <= pend_d;
      overflow_q     <= overflow_q | (wr_valid & ~wr_ready);
    end
endmodule

// File: tb/tb_tqvp_vga_write_scheduler.sv
// tb_tqvp_vga_write_scheduler: directed checks of window gating, FIFO order, full/overflow, fence and reset.
module tb_tqvp_vga_write_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  wr_size = 2'b10;
  logic        wr_ready;
  logic [1:0]  sync_mode = 2'b00;
  logic        blank = 1'b0;
  logic        vblank = 1'b0;
  logic        fence_req = 1'b0;
  logic        fence_done, commit_valid, overflow;
  logic [5:0]  commit_addr;
  logic [31:0] commit_data;
  logic [1:0]  commit_size;
  logic [2:0]  level;
  int checks = 0;
  int errors = 0;

  tqvp_vga_write_scheduler #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_size(wr_size), .wr_ready(wr_ready), .sync_mode(sync_mode), .blank(blank), .vblank(vblank),
    .fence_req(fence_req), .fence_done(fence_done), .commit_valid(commit_valid),
    .commit_addr(commit_addr), .commit_data(commit_data), .commit_size(commit_size),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_cv", 64'(commit_valid), 64'(0));
    chk("rst_data", 64'(commit_data), 64'(0));
    chk("rst_ready", 64'(wr_ready), 64'(1));
    chk("rst_fence", 64'(fence_done), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));

    // immediate mode: one write, commit two edges after it is presented
    wr_valid = 1'b1; wr_addr = 6'h01; wr_data = 32'hDEADBEEF; wr_size = 2'b10;
    chk("t1_ready", 64'(wr_ready), 64'(1));
    tick();
    wr_valid = 1'b0;
    chk("t1_level1", 64'(level), 64'(1));
    chk("t1_cv0", 64'(commit_valid), 64'(0));
    tick();
    chk("t1_cv1", 64'(commit_valid), 64'(1));
    chk("t1_addr", 64'(commit_addr), 64'(6'h01));
    chk("t1_data", 64'(commit_data), 64'(32'hDEADBEEF));
    chk("t1_size", 64'(commit_size), 64'(2'b10));
    chk("t1_level0", 64'(level), 64'(0));
    tick();
    chk("t1_cv_drop", 64'(commit_valid), 64'(0));
    chk("t1_hold", 64'(commit_data), 64'(32'hDEADBEEF));

    // any-blank mode: fill while not blanking, overflow, then drain in order
    sync_mode = 2'b01; blank = 1'b0;
    for (int i = 0; i < 4; i++) push(6'(6'h10 + i), 32'hA0 + i);
    chk("t2_level4", 64'(level), 64'(4));
    chk("t2_ready0", 64'(wr_ready), 64'(0));
    chk("t2_cv0", 64'(commit_valid), 64'(0));
    chk("t2_ovf0", 64'(overflow), 64'(0));
    push(6'h3F, 32'hFFFF);
    chk("t2_ovf1", 64'(overflow), 64'(1));
    chk("t2_level_keep", 64'(level), 64'(4));
    blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_cv", 64'(commit_valid), 64'(1));
      chk("t2_addr", 64'(commit_addr), 64'(6'h10 + i));
      chk("t2_data", 64'(commit_data), 64'(32'hA0 + i));
    end
    chk("t2_level0", 64'(level), 64'(0));
    blank = 1'b0;
    tick();
    chk("t2_cv_end", 64'(commit_valid), 64'(0));

    // vblank-only mode: hblank ignored, two vblank cycles release two entries
    sync_mode = 2'b10; blank = 1'b1;
    for (int i = 0; i < 3; i++) push(6'(6'h20 + i), 32'hB0 + i);
    tick();
    tick();
    chk("t3_no_commit", 64'(commit_valid), 64'(0));
    chk("t3_level3", 64'(level), 64'(3));
    vblank = 1'b1;
    tick();
    chk("t3_cv_a", 64'(commit_valid), 64'(1));
    chk("t3_addr_a", 64'(commit_addr), 64'(6'h20));
    tick();
    chk("t3_cv_b", 64'(commit_valid), 64'(1));
    chk("t3_addr_b", 64'(commit_addr), 64'(6'h21));
    vblank = 1'b0;
    chk("t3_level1", 64'(level), 64'(1));
    tick();
    chk("t3_cv_c", 64'(commit_valid), 64'(0));
    chk("t3_level_rem", 64'(level), 64'(1));
    chk("t3_addr_hold", 64'(commit_addr), 64'(6'h21));
    sync_mode = 2'b00; blank = 1'b0;
    tick();
    chk("t3_last", 64'(commit_addr), 64'(6'h22));
    chk("t3_level0", 64'(level), 64'(0));

    // streaming through an open window, pointers wrap several times
    sync_mode = 2'b01; blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_addr = 6'(i); wr_data = 32'hC000 + i;
      chk("t4_ready", 64'(wr_ready), 64'(1));
      tick();
      chk("t4_level_le2", 64'(level <= 3'd2), 64'(1));
      if (i > 0) begin
        chk("t4_cv", 64'(commit_valid), 64'(1));
        chk("t4_data", 64'(commit_data), 64'(32'hC000 + i - 1));
      end
    end
    wr_valid = 1'b0;
    tick();
    chk("t4_last", 64'(commit_data), 64'(32'hC000 + 19));
    chk("t4_level0", 64'(level), 64'(0));
    blank = 1'b0;

    // fence waits through a hold, pulses once after the drain
    sync_mode = 2'b11;
    for (int i = 0; i < 3; i++) push(6'(6'h30 + i), 32'hD0 + i);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_nofence", 64'(fence_done), 64'(0));
      chk("t5_hold_level", 64'(level), 64'(3));
      tick();
    end
    sync_mode = 2'b00;
    tick();
    tick();
    tick();
    chk("t5_level0", 64'(level), 64'(0));
    chk("t5_last_addr", 64'(commit_addr), 64'(6'h32));
    chk("t5_fence_early", 64'(fence_done), 64'(0));
    tick();
    chk("t5_fence_pulse", 64'(fence_done), 64'(1));
    tick();
    chk("t5_fence_clear", 64'(fence_done), 64'(0));

    // fence on empty queue completes next cycle
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("t5_empty_fence", 64'(fence_done), 64'(1));
    tick();
    chk("t5_empty_clear", 64'(fence_done), 64'(0));

    // repeated fence_req while pending yields a single pulse
    sync_mode = 2'b11;
    push(6'h05, 32'h55);
    fence_req = 1'b1;
    tick();
    tick();
    fence_req = 1'b0;
    chk("t5_dup_wait", 64'(fence_done), 64'(0));
    sync_mode = 2'b00;
    tick();
    chk("t5_dup_drain", 64'(fence_done), 64'(0));
    tick();
    chk("t5_dup_pulse", 64'(fence_done), 64'(1));
    tick();
    chk("t5_dup_once", 64'(fence_done), 64'(0));
    tick();
    chk("t5_dup_once2", 64'(fence_done), 64'(0));

    // reset drops queued writes and the pending fence
    sync_mode = 2'b11;
    for (int i = 0; i < 3; i++) push(6'(6'h38 + i), 32'hE0 + i);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("t6_pre_level", 64'(level), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_cv", 64'(commit_valid), 64'(0));
    chk("t6_ovf", 64'(overflow), 64'(0));
    chk("t6_ready", 64'(wr_ready), 64'(1));
    sync_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_fence", 64'(fence_done), 64'(0));
      chk("t6_no_commit", 64'(commit_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
